// File: rtl/id_stage.sv
// Decode stage: decodes the IF/ID slot, detects load-use hazards and registers ID/EX (1-cycle latency).
// Stalls IF/ID on load-use or halt; optional writeback->ID operand bypass with `define WB_BYPASS_EN.
package mips_pkg;
    parameter int DATA           = 32;
    parameter int REGISTERWIDTH  = 5;
    parameter int REGISTERNUMBER = 32;
endpackage

module id_stage #(
    parameter int DATA           = mips_pkg::DATA,
    parameter int REGISTERWIDTH  = mips_pkg::REGISTERWIDTH,
    parameter int REGISTERNUMBER = mips_pkg::REGISTERNUMBER
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid_i,
    input  logic [31:0]              instr_i,
    input  logic [31:0]              pc_i,
    input  logic                     flush_i,
    output logic [REGISTERWIDTH-1:0] rs1_o,
    output logic [REGISTERWIDTH-1:0] rs2_o,
    input  logic [DATA-1:0]          readData1_i,
    input  logic [DATA-1:0]          readData2_i,
    input  logic                     wb_we_i,
    input  logic [REGISTERWIDTH-1:0] wb_rd_i,
    input  logic [DATA-1:0]          wb_data_i,
    output logic                     idex_valid_o,
    output logic [5:0]               idex_op_o,
    output logic [DATA-1:0]          idex_a_o,
    output logic [DATA-1:0]          idex_b_o,
    output logic [31:0]              idex_imm_o,
    output logic [REGISTERWIDTH-1:0] idex_dest_o,
    output logic                     idex_we_o,
    output logic                     idex_isload_o,
    output logic [31:0]              idex_pc_o,
    output logic                     stall_o,
    output logic                     halt_o,
    output logic [15:0]              stall_count_o
);
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;
    localparam logic [REGISTERNUMBER-1:0] ONE = 1;

    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

    state_t                     state_q;
    logic                       halt_q;
    logic [15:0]                stall_cnt_q;
    logic                       idex_valid_q, idex_we_q, idex_isload_q;
    logic [5:0]                 idex_op_q;
    logic [DATA-1:0]            idex_a_q, idex_b_q;
    logic [31:0]                idex_imm_q, idex_pc_q;
    logic [REGISTERWIDTH-1:0]   idex_dest_q;

    logic [5:0]                 op;
    logic [REGISTERWIDTH-1:0]   rs, rt, rd, dest_d;
    logic                       is_rtype, is_itype, is_ldw, rs_used, rt_used;
    logic [REGISTERNUMBER-1:0]  src_mask;
    logic                       hazard, load_en;
    logic [DATA-1:0]            opa_d, opb_d;

    assign op       = instr_i[31:26];
    assign rs       = instr_i[25:21];
    assign rt       = instr_i[20:16];
    assign rd       = instr_i[15:11];
    assign rs1_o    = rs;
    assign rs2_o    = rt;

    assign is_rtype = (op <= 6'h0A) && !op[0];
    assign is_itype = (op <= 6'h0B) && op[0];
    assign is_ldw   = (op == OP_LDW);
    assign rs_used  = (op <= OP_JR);
    assign rt_used  = is_rtype || (op == OP_STW) || (op == OP_BEQ);
    // Instructions without a destination carry dest 0, which also suppresses the write.
    assign dest_d   = is_rtype ? rd : ((is_itype || is_ldw) ? rt : '0);

    assign src_mask = (rs_used ? (ONE << rs) : '0) | (rt_used ? (ONE << rt) : '0);
    assign hazard   = instr_valid_i && idex_valid_q && idex_isload_q
                      && (idex_dest_q != '0) && src_mask[idex_dest_q];
    assign stall_o  = (hazard && !flush_i) || (state_q != RUN);
    assign load_en  = instr_valid_i && !flush_i && (state_q == RUN) && !hazard;

`ifdef WB_BYPASS_EN
    assign opa_d = (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs)) ? wb_data_i : readData1_i;
    assign opb_d = (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rt)) ? wb_data_i : readData2_i;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we_i, wb_rd_i, wb_data_i};
    assign opa_d     = readData1_i;
    assign opb_d     = readData2_i;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            halt_q        <= 1'b0;
            stall_cnt_q   <= '0;
            idex_valid_q  <= 1'b0;
            idex_we_q     <= 1'b0;
            idex_isload_q <= 1'b0;
            idex_op_q     <= '0;
            idex_a_q      <= '0;
            idex_b_q      <= '0;
            idex_imm_q    <= '0;
            idex_pc_q     <= '0;
            idex_dest_q   <= '0;
        end else begin
            idex_valid_q  <= load_en;
            idex_we_q     <= load_en && (dest_d != '0);
            idex_isload_q <= load_en && is_ldw;
            idex_op_q     <= load_en ? op : '0;
            idex_a_q      <= load_en ? opa_d : '0;
            idex_b_q      <= load_en ? opb_d : '0;
            idex_imm_q    <= load_en ? {{16{instr_i[15]}}, instr_i[15:0]} : '0;
            idex_pc_q     <= load_en ? pc_i : '0;
            idex_dest_q   <= load_en ? dest_d : '0;

            if (hazard && !flush_i && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;

            // A HALT still in EX can be killed by a taken branch ahead of it.
            case (state_q)
                RUN:       if (load_en && (op == OP_HALT)) state_q <= HALT_PEND;
                HALT_PEND: state_q <= flush_i ? RUN : HALTED;
                HALTED:    state_q <= HALTED;
                default:   state_q <= RUN;
            endcase
            halt_q <= ((state_q == HALT_PEND) && !flush_i) || (state_q == HALTED);
        end
    end

    assign idex_valid_o  = idex_valid_q;
    assign idex_we_o     = idex_we_q;
    assign idex_isload_o = idex_isload_q;
    assign idex_op_o     = idex_op_q;
    assign idex_a_o      = idex_a_q;
    assign idex_b_o      = idex_b_q;
    assign idex_imm_o    = idex_imm_q;
    assign idex_pc_o     = idex_pc_q;
    assign idex_dest_o   = idex_dest_q;
    assign halt_o        = halt_q;
    assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus hazard, bypass, halt and reset sequences.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid_i;
    logic [31:0] instr_i, pc_i;
    logic        flush_i;
    logic [4:0]  rs1_o, rs2_o;
    logic [31:0] readData1_i, readData2_i;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        idex_valid_o, idex_we_o, idex_isload_o;
    logic [5:0]  idex_op_o;
    logic [31:0] idex_a_o, idex_b_o, idex_imm_o, idex_pc_o;
    logic [4:0]  idex_dest_o;
    logic        stall_o, halt_o;
    logic [15:0] stall_count_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .instr_valid_i(instr_valid_i), .instr_i(instr_i),
        .pc_i(pc_i), .flush_i(flush_i), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .readData1_i(readData1_i), .readData2_i(readData2_i), .wb_we_i(wb_we_i),
        .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .idex_valid_o(idex_valid_o),
        .idex_op_o(idex_op_o), .idex_a_o(idex_a_o), .idex_b_o(idex_b_o),
        .idex_imm_o(idex_imm_o), .idex_dest_o(idex_dest_o), .idex_we_o(idex_we_o),
        .idex_isload_o(idex_isload_o), .idex_pc_o(idex_pc_o), .stall_o(stall_o),
        .halt_o(halt_o), .stall_count_o(stall_count_o)
    );

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic        fl;
        logic [31:0] r1, r2;
        logic        e_st;
        logic        e_v;
        logic [5:0]  e_op;
        logic [31:0] e_a, e_b, e_imm;
        logic [4:0]  e_dest;
        logic        e_we, e_ld;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    function automatic logic [31:0] rins(input logic [5:0] op, input logic [4:0] s, t, d);
        return {op, s, t, d, 11'd0};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] op, input logic [4:0] s, t,
                                         input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                         input logic [31:0] r1, input logic [31:0] r2);
        instr_valid_i = v;
        instr_i       = ins;
        flush_i       = fl;
        readData1_i   = r1;
        readData2_i   = r2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_a;
        tbl[0]  = '{1'b1, iins(6'h01, 5'd1, 5'd3, 16'hFFFB), 1'b0, 32'd10, 32'h22,
                    1'b0, 1'b1, 6'h01, 32'd10, 32'h22, 32'hFFFF_FFFB, 5'd3, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, rins(6'h00, 5'd1, 5'd2, 5'd4), 1'b0, 32'd5, 32'd7,
                    1'b0, 1'b1, 6'h00, 32'd5, 32'd7, 32'h0000_2000, 5'd4, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, rins(6'h0A, 5'd1, 5'd2, 5'd0), 1'b0, 32'd1, 32'd2,
                    1'b0, 1'b1, 6'h0A, 32'd1, 32'd2, 32'h0, 5'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, iins(6'h0D, 5'd5, 5'd6, 16'h8000), 1'b0, 32'h1000, 32'hDEAD,
                    1'b0, 1'b1, 6'h0D, 32'h1000, 32'hDEAD, 32'hFFFF_8000, 5'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, iins(6'h0C, 5'd2, 5'd9, 16'h0010), 1'b0, 32'h200, 32'h0,
                    1'b0, 1'b1, 6'h0C, 32'h200, 32'h0, 32'h10, 5'd9, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, iins(6'h07, 5'd3, 5'd9, 16'h0001), 1'b0, 32'd3, 32'd4,
                    1'b0, 1'b1, 6'h07, 32'd3, 32'd4, 32'h1, 5'd9, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, iins(6'h0C, 5'd1, 5'd12, 16'hFFFF), 1'b0, 32'd8, 32'h0,
                    1'b0, 1'b1, 6'h0C, 32'd8, 32'h0, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, iins(6'h0E, 5'd12, 5'd0, 16'h0004), 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, iins(6'h0E, 5'd12, 5'd0, 16'h0004), 1'b0, 32'h77, 32'h0,
                    1'b0, 1'b1, 6'h0E, 32'h77, 32'h0, 32'h4, 5'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, rins(6'h00, 5'd1, 5'd2, 5'd4), 1'b0, 32'd9, 32'd9,
                    1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, iins(6'h3F, 5'd1, 5'd2, 16'h1234), 1'b0, 32'h11, 32'h22,
                    1'b0, 1'b1, 6'h3F, 32'h11, 32'h22, 32'h1234, 5'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, rins(6'h00, 5'd1, 5'd2, 5'd4), 1'b1, 32'd9, 32'd9,
                    1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, iins(6'h10, 5'd31, 5'd0, 16'h0000), 1'b0, 32'h400, 32'h0,
                    1'b0, 1'b1, 6'h10, 32'h400, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, iins(6'h05, 5'd1, 5'd0, 16'h0002), 1'b0, 32'd3, 32'h0,
                    1'b0, 1'b1, 6'h05, 32'd3, 32'h0, 32'h2, 5'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, iins(6'h0C, 5'd1, 5'd0, 16'h0000), 1'b0, 32'h50, 32'h0,
                    1'b0, 1'b1, 6'h0C, 32'h50, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, rins(6'h00, 5'd0, 5'd0, 5'd5), 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b1, 6'h00, 32'h0, 32'h0, 32'h2800, 5'd5, 1'b1, 1'b0};
        tbl[16] = '{1'b1, iins(6'h0B, 5'd2, 5'd7, 16'h7FFF), 1'b0, 32'd1, 32'd2,
                    1'b0, 1'b1, 6'h0B, 32'd1, 32'd2, 32'h7FFF, 5'd7, 1'b1, 1'b0};
        tbl[17] = '{1'b1, rins(6'h0F, 5'd1, 5'd2, 5'd0), 1'b0, 32'd4, 32'd4,
                    1'b0, 1'b1, 6'h0F, 32'd4, 32'd4, 32'h0, 5'd0, 1'b0, 1'b0};

        // Reset overrides a valid instruction in the slot.
        reset = 1'b1; pc_i = 32'h40;
        wb_we_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0;
        drive(1'b1, rins(6'h00, 5'd1, 5'd2, 5'd4), 1'b0, 32'h5, 32'h6);
        tick;
        chk("rst_valid", {31'd0, idex_valid_o}, 32'd0);
        chk("rst_a", idex_a_o, 32'd0);
        chk("rst_pc", idex_pc_o, 32'd0);
        chk("rst_we", {31'd0, idex_we_o}, 32'd0);
        chk("rst_halt", {31'd0, halt_o}, 32'd0);
        chk("rst_cnt", {16'd0, stall_count_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].instr, tbl[i].fl, tbl[i].r1, tbl[i].r2);
            pc_i = 32'h100 + 32'(i * 4);
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, tbl[i].e_st});
            chk($sformatf("v%0d_rs1", i), {27'd0, rs1_o}, {27'd0, tbl[i].instr[25:21]});
            chk($sformatf("v%0d_rs2", i), {27'd0, rs2_o}, {27'd0, tbl[i].instr[20:16]});
            tick;
            chk($sformatf("v%0d_valid", i), {31'd0, idex_valid_o}, {31'd0, tbl[i].e_v});
            chk($sformatf("v%0d_op", i), {26'd0, idex_op_o}, {26'd0, tbl[i].e_op});
            chk($sformatf("v%0d_a", i), idex_a_o, tbl[i].e_a);
            chk($sformatf("v%0d_b", i), idex_b_o, tbl[i].e_b);
            chk($sformatf("v%0d_imm", i), idex_imm_o, tbl[i].e_imm);
            chk($sformatf("v%0d_dest", i), {27'd0, idex_dest_o}, {27'd0, tbl[i].e_dest});
            chk($sformatf("v%0d_we", i), {31'd0, idex_we_o}, {31'd0, tbl[i].e_we});
            chk($sformatf("v%0d_ld", i), {31'd0, idex_isload_o}, {31'd0, tbl[i].e_ld});
            chk($sformatf("v%0d_pc", i), idex_pc_o, tbl[i].e_v ? 32'h100 + 32'(i * 4) : 32'h0);
        end
        chk("tbl_cnt", {16'd0, stall_count_o}, 32'd1);

        // Load-use on rs: one stall cycle, one bubble, then the ADD issues.
        reset = 1'b1; drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0); tick; reset = 1'b0;
        drive(1'b1, iins(6'h0C, 5'd1, 5'd2, 16'h0), 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, rins(6'h00, 5'd2, 5'd5, 5'd4), 1'b0, 32'h33, 32'h44); #1;
        chk("lu_stall", {31'd0, stall_o}, 32'd1);
        tick;
        chk("lu_bubble", {31'd0, idex_valid_o}, 32'd0);
        chk("lu_cnt", {16'd0, stall_count_o}, 32'd1);
        chk("lu_release", {31'd0, stall_o}, 32'd0);
        tick;
        chk("lu_issue_v", {31'd0, idex_valid_o}, 32'd1);
        chk("lu_issue_dest", {27'd0, idex_dest_o}, 32'd4);
        chk("lu_issue_a", idex_a_o, 32'h33);

        // Load-use through rt of a store.
        drive(1'b1, iins(6'h0C, 5'd1, 5'd2, 16'h0), 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, iins(6'h0D, 5'd6, 5'd2, 16'h0), 1'b0, 32'h0, 32'h0); #1;
        chk("lu_rt_stall", {31'd0, stall_o}, 32'd1);
        tick;
        chk("lu_rt_cnt", {16'd0, stall_count_o}, 32'd2);
        tick;

        // Hazard coinciding with flush: no stall, bubble, count held.
        drive(1'b1, iins(6'h0C, 5'd1, 5'd2, 16'h0), 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, rins(6'h00, 5'd2, 5'd5, 5'd4), 1'b1, 32'h0, 32'h0); #1;
        chk("fl_haz_stall", {31'd0, stall_o}, 32'd0);
        tick;
        chk("fl_haz_valid", {31'd0, idex_valid_o}, 32'd0);
        chk("fl_haz_cnt", {16'd0, stall_count_o}, 32'd2);

        // Reset asserted mid-stall clears the counter.
        drive(1'b1, iins(6'h0C, 5'd1, 5'd2, 16'h0), 1'b0, 32'h0, 32'h0); tick;
        drive(1'b1, rins(6'h00, 5'd2, 5'd5, 5'd4), 1'b0, 32'h0, 32'h0);
        reset = 1'b1; tick; reset = 1'b0;
        chk("rst_stall_cnt", {16'd0, stall_count_o}, 32'd0);
        chk("rst_stall_v", {31'd0, idex_valid_o}, 32'd0);

        // Writeback in the same cycle as decode of a reader.
        wb_we_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'hAA;
        drive(1'b1, rins(6'h02, 5'd7, 5'd0, 5'd1), 1'b0, 32'h55, 32'h0); tick;
`ifdef WB_BYPASS_EN
        exp_a = 32'hAA;
`else
        exp_a = 32'h55;
`endif
        chk("wb_a", idex_a_o, exp_a);
        chk("wb_b", idex_b_o, 32'h0);
        wb_rd_i = 5'd0; wb_data_i = 32'hBB;
        drive(1'b1, rins(6'h02, 5'd0, 5'd0, 5'd1), 1'b0, 32'h0, 32'h0); tick;
        chk("wb_r0_a", idex_a_o, 32'h0);
        wb_we_i = 1'b0;

        // HALT killed by a flush in the following cycle.
        drive(1'b1, {6'h11, 26'd0}, 1'b0, 32'h0, 32'h0); tick;
        chk("hf_op", {26'd0, idex_op_o}, 32'h11);
        drive(1'b1, rins(6'h00, 5'd1, 5'd2, 5'd4), 1'b1, 32'h0, 32'h0); #1;
        chk("hf_pend_stall", {31'd0, stall_o}, 32'd1);
        tick;
        chk("hf_halt", {31'd0, halt_o}, 32'd0);
        chk("hf_bubble", {31'd0, idex_valid_o}, 32'd0);
        drive(1'b1, rins(6'h00, 5'd1, 5'd2, 5'd4), 1'b0, 32'h9, 32'h0); #1;
        chk("hf_run_stall", {31'd0, stall_o}, 32'd0);
        tick;
        chk("hf_issue", {31'd0, idex_valid_o}, 32'd1);
        chk("hf_issue_a", idex_a_o, 32'h9);

        // HALT that retires: halted from the second edge, bubbles while halted.
        drive(1'b1, {6'h11, 26'd0}, 1'b0, 32'h0, 32'h0); tick;
        chk("h_pend_halt", {31'd0, halt_o}, 32'd0);
        drive(1'b1, rins(6'h00, 5'd1, 5'd2, 5'd4), 1'b0, 32'h0, 32'h0); tick;
        chk("h_halt1", {31'd0, halt_o}, 32'd1);
        chk("h_bubble1", {31'd0, idex_valid_o}, 32'd0);
        tick;
        chk("h_halt2", {31'd0, halt_o}, 32'd1);
        chk("h_bubble2", {31'd0, idex_valid_o}, 32'd0);
        chk("h_stall", {31'd0, stall_o}, 32'd1);

        // Reset out of HALTED.
        reset = 1'b1; tick; reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0); #1;
        chk("hr_halt", {31'd0, halt_o}, 32'd0);
        chk("hr_stall", {31'd0, stall_o}, 32'd0);
        chk("hr_valid", {31'd0, idex_valid_o}, 32'd0);
        chk("hr_op", {26'd0, idex_op_o}, 32'd0);
        chk("hr_imm", idex_imm_o, 32'd0);
        chk("hr_cnt", {16'd0, stall_count_o}, 32'd0);
        drive(1'b1, rins(6'h00, 5'd1, 5'd2, 5'd4), 1'b0, 32'h3, 32'h0); tick;
        chk("hr_issue", {31'd0, idex_valid_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameters from mips_pkg: DATA=32 (data width), REGISTERWIDTH=5 (register index width), REGISTERNUMBER=32 (register count).
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have instr_valid_i, input, 1, the IF/ID slot holds a real instruction.
REQ-005 SHALL have instr_i, input, 32: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
REQ-006 SHALL have pc_i, input, 32, PC of instr_i.
REQ-007 SHALL have flush_i, input, 1, EX branch-taken kill of the ID slot.
REQ-008 SHALL have rs1_o and rs2_o, output, REGISTERWIDTH each, register-file read indices, driven combinationally as instr_i[25:21] and instr_i[20:16].
REQ-009 SHALL have readData1_i and readData2_i, input, DATA each, register-file read data; index 0 reads zero.
REQ-010 SHALL have wb_we_i (1), wb_rd_i (REGISTERWIDTH) and wb_data_i (DATA), all inputs, the writeback port driving the register file this cycle.
REQ-011 SHALL have ID/EX outputs: idex_valid_o 1, idex_op_o 6, idex_a_o DATA, idex_b_o DATA, idex_imm_o 32 (sign-extended), idex_dest_o 5, idex_we_o 1, idex_isload_o 1, idex_pc_o 32.
REQ-012 SHALL have outputs stall_o 1 (hold IF/ID and PC), halt_o 1 (processor halted) and stall_count_o 16 (load-use stall cycles).

Function
REQ-013 SHALL decode opcodes as follows: ADD/SUB/MUL/OR/AND/XOR are even opcodes 0x00-0x0A; the I-type forms are those opcodes +1; LDW 0x0C, STW 0x0D, BZ 0x0E, BEQ 0x0F, JR 0x10, HALT 0x11; any other opcode is a NOP.
REQ-014 SHALL treat rs as used by all of the above except HALT and NOP; rt as used by R-type, STW and BEQ.
REQ-015 SHALL set dest: R-type gets rd; I-type arithmetic and LDW get rt; all others get none. idex_we_o=1 only when a dest exists and dest!=0.
REQ-016 SHALL detect a load-use hazard: instr_valid_i, idex_valid_o, idex_isload_o, idex_dest_o!=0, and idex_dest_o equals a used source.
REQ-017 SHALL compute stall_o combinationally = (load-use hazard & ~flush_i) | state!=RUN.
REQ-018 SHALL update ID/EX once per cycle, priority top to bottom:
- reset: clear
- flush_i: bubble
- state!=RUN: bubble
- hazard: bubble
- instr_valid_i: load decoded instruction
- else: bubble
REQ-019 SHALL make a bubble idex_valid_o=0, idex_we_o=0 and idex_isload_o=0, with other fields 0.
REQ-020 SHALL give a latency of 1 cycle from ID to the ID/EX outputs.
REQ-021 SHALL load idex_a_o/idex_b_o from the (bypassed) rs/rt read data and idex_imm_o from {16{imm[15]},imm}.
REQ-022 SHALL use the state machine RUN, HALT_PEND and HALTED:
- RUN to HALT_PEND when a valid HALT is loaded into ID/EX
- HALT_PEND to RUN if flush_i that cycle, else to HALTED
- HALTED is left only by reset
REQ-023 SHALL assert halt_o only in HALTED.
REQ-024 SHALL increment stall_count_o in each cycle where the load-use hazard causes stall_o, saturating at 0xFFFF (no wrap).
REQ-025 SHALL give flush_i and a hazard in the same cycle a bubble with no stall and no count.

Reset
REQ-026 SHALL on reset set state=RUN, all idex_* outputs 0, halt_o=0 and stall_count_o=0; stall_o is then 0 unless a hazard exists, which is impossible because idex_valid_o=0.
REQ-027 SHALL let reset asserted mid-stall or in HALTED take effect at the next edge, overriding all other inputs.

Configuration
REQ-028 SHALL, with macro WB_BYPASS_EN defined, use wb_data_i as a source value when wb_we_i=1, wb_rd_i!=0 and wb_rd_i equals that source index.
REQ-029 SHALL, without WB_BYPASS_EN, pass readData1_i/readData2_i through unmodified, leaving same-cycle WB/ID conflicts to software spacing.

Verification
REQ-030 SHALL cover: ADDI r3,r1,-5 with readData1=10 -> next cycle idex_valid=1, a=10, imm=0xFFFFFFFB, dest=3, we=1.
REQ-031 SHALL cover: LDW r2 then ADD r4,r2,r5 -> stall_o=1 for 1 cycle, one bubble, stall_count_o=1, then the ADD issues.
REQ-032 SHALL cover: wb_we=1, wb_rd=7, wb_data=0xAA while decoding SUB r1,r7,r0 -> a=0xAA with WB_BYPASS_EN; a=readData1_i without it.
REQ-033 SHALL cover: HALT in ID then flush_i next cycle -> back to RUN, halt_o stays 0; HALT without flush -> halt_o=1 from the 2nd cycle, bubbles thereafter.
REQ-034 SHALL cover: load-use hazard with flush_i=1 -> stall_o=0, bubble, count unchanged; reset during HALTED -> all outputs 0, state RUN.
